// File: rtl/wash_sequencer.sv
// rtl/wash_sequencer.sv - timed FILL/WASH/RINSE/SPIN program sequencer with BCD countdown
// Optional pause support is built only when WASH_SEQ_PAUSE_EN is defined.
module wash_sequencer #(
    parameter int CLK_HZ  = 100_000_000,
    parameter int FILL_S  = 5,
    parameter int WASH_S  = 30,
    parameter int RINSE_S = 20,
    parameter int SPIN_S  = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic [1:0] mode,
    output logic [2:0] phase,
    output logic [3:0] n1,
    output logic [3:0] n2,
    output logic [3:0] n3,
    output logic [3:0] n0,
    output logic [7:0] st_light,
    output logic       valve,
    output logic [1:0] motor,
    output logic       busy,
    output logic       done
);

    localparam logic [2:0] PH_IDLE  = 3'd0;
    localparam logic [2:0] PH_FILL  = 3'd1;
    localparam logic [2:0] PH_WASH  = 3'd2;
    localparam logic [2:0] PH_RINSE = 3'd3;
    localparam logic [2:0] PH_SPIN  = 3'd4;
    localparam logic [2:0] PH_DONE  = 3'd5;

    localparam logic [1:0] MODE_FWS  = 2'b01;
    localparam logic [1:0] MODE_SPIN = 2'b10;
    localparam logic [1:0] MODE_FRS  = 2'b11;

    localparam int            PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PS_MAX = PW'(CLK_HZ - 1);

    // Binary seconds to three packed BCD digits (hundreds:tens:ones).
    function automatic logic [11:0] to_bcd(input int v);
        to_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    localparam logic [11:0] FILL_BCD  = to_bcd(FILL_S);
    localparam logic [11:0] WASH_BCD  = to_bcd(WASH_S);
    localparam logic [11:0] RINSE_BCD = to_bcd(RINSE_S);
    localparam logic [11:0] SPIN_BCD  = to_bcd(SPIN_S);

    // Duration loaded on entry to a phase; IDLE and DONE show 000.
    function automatic logic [11:0] phase_dur(input logic [2:0] ph);
        case (ph)
            PH_FILL:  phase_dur = FILL_BCD;
            PH_WASH:  phase_dur = WASH_BCD;
            PH_RINSE: phase_dur = RINSE_BCD;
            PH_SPIN:  phase_dur = SPIN_BCD;
            default:  phase_dur = 12'h000;
        endcase
    endfunction

    // Successor of a busy phase within the chain selected by the latched mode.
    function automatic logic [2:0] next_phase(input logic [1:0] m, input logic [2:0] ph);
        case (ph)
            PH_FILL:  next_phase = (m == MODE_FRS) ? PH_RINSE : PH_WASH;
            PH_WASH:  next_phase = (m == MODE_FWS) ? PH_SPIN : PH_RINSE;
            PH_RINSE: next_phase = PH_SPIN;
            default:  next_phase = PH_DONE;
        endcase
    endfunction

    // BCD decrement with borrow; never called on 000 or 001.
    function automatic logic [11:0] bcd_dec(input logic [11:0] v);
        logic [3:0] d2, d1, d0;
        d2 = v[11:8];
        d1 = v[7:4];
        d0 = v[3:0];
        if (d0 != 4'd0) begin
            d0 = d0 - 4'd1;
        end else begin
            d0 = 4'd9;
            if (d1 != 4'd0) begin
                d1 = d1 - 4'd1;
            end else begin
                d1 = 4'd9;
                d2 = d2 - 4'd1;
            end
        end
        bcd_dec = {d2, d1, d0};
    endfunction

    logic          pause_eff;
`ifdef WASH_SEQ_PAUSE_EN
    assign pause_eff = pause;
`else
    logic          unused_pause;
    assign unused_pause = pause;
    assign pause_eff    = 1'b0;
`endif

    logic [2:0]    phase_q, phase_d;
    logic [1:0]    mode_q, mode_d;
    logic [PW-1:0] cnt_q, cnt_d;
    logic [11:0]   bcd_q, bcd_d;
    logic [3:0]    n0_q, n0_d;
    logic [7:0]    st_light_q, st_light_d;
    logic          valve_q, valve_d;
    logic [1:0]    motor_q, motor_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          paused_d;
    logic          tick;

    // A tick is taken even if pause rises in the same cycle; the freeze starts after it.
    assign tick = busy_q && (cnt_q == PS_MAX);

    // Program state: stop beats start, start only from IDLE/DONE, ticks drive the countdown.
    always_comb begin
        phase_d = phase_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        if (stop) begin
            phase_d = PH_IDLE;
            bcd_d   = 12'h000;
            cnt_d   = '0;
        end else if (start && (phase_q == PH_IDLE || phase_q == PH_DONE)) begin
            mode_d  = mode;
            phase_d = (mode == MODE_SPIN) ? PH_SPIN : PH_FILL;
            bcd_d   = phase_dur(phase_d);
            cnt_d   = '0;
        end else if (busy_q) begin
            if (tick) begin
                cnt_d = '0;
                if (bcd_q == 12'h001) begin
                    phase_d = next_phase(mode_q, phase_q);
                    bcd_d   = phase_dur(phase_d);
                end else begin
                    bcd_d = bcd_dec(bcd_q);
                end
            end else if (!pause_eff) begin
                cnt_d = cnt_q + PW'(1);
            end
        end
    end

    // Registered output decode from the next phase, with the pause override on top.
    always_comb begin
        valve_d    = 1'b0;
        motor_d    = 2'b00;
        st_light_d = 8'h00;
        n0_d       = 4'd0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        case (phase_d)
            PH_FILL:  begin valve_d = 1'b1; st_light_d = 8'h01; n0_d = 4'd1; busy_d = 1'b1; end
            PH_WASH:  begin motor_d = 2'b01; st_light_d = 8'h03; n0_d = 4'd2; busy_d = 1'b1; end
            PH_RINSE: begin motor_d = 2'b01; st_light_d = 8'h07; n0_d = 4'd3; busy_d = 1'b1; end
            PH_SPIN:  begin motor_d = 2'b10; st_light_d = 8'h0F; n0_d = 4'd4; busy_d = 1'b1; end
            PH_DONE:  begin st_light_d = 8'hFF; done_d = 1'b1; end
            default:  ;
        endcase
        paused_d = pause_eff && busy_d;
        if (paused_d) begin
            valve_d    = 1'b0;
            motor_d    = 2'b00;
            n0_d       = 4'd10;
            st_light_d = st_light_d | 8'h80;
        end
    end

    // State and output registers; reset clears everything without waiting for a clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q    <= PH_IDLE;
            mode_q     <= 2'b00;
            cnt_q      <= '0;
            bcd_q      <= 12'h000;
            n0_q       <= 4'd0;
            st_light_q <= 8'h00;
            valve_q    <= 1'b0;
            motor_q    <= 2'b00;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            phase_q    <= phase_d;
            mode_q     <= mode_d;
            cnt_q      <= cnt_d;
            bcd_q      <= bcd_d;
            n0_q       <= n0_d;
            st_light_q <= st_light_d;
            valve_q    <= valve_d;
            motor_q    <= motor_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign phase    = phase_q;
    assign n3       = bcd_q[11:8];
    assign n2       = bcd_q[7:4];
    assign n1       = bcd_q[3:0];
    assign n0       = n0_q;
    assign st_light = st_light_q;
    assign valve    = valve_q;
    assign motor    = motor_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_wash_sequencer.sv
// tb/tb_wash_sequencer.sv - directed self-checking bench for wash_sequencer
module tb_wash_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic       pause;
    logic [1:0] mode;

    logic [2:0] phase, phase5;
    logic [3:0] n1, n2, n3, n0, n1_5, n2_5, n3_5, n0_5;
    logic [7:0] st_light, st_light5;
    logic       valve, valve5, busy, busy5, done, done5;
    logic [1:0] motor, motor5;

    int checks   = 0;
    int failures = 0;

    wash_sequencer #(.CLK_HZ(4), .FILL_S(2), .WASH_S(3), .RINSE_S(2), .SPIN_S(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .mode(mode),
        .phase(phase), .n1(n1), .n2(n2), .n3(n3), .n0(n0), .st_light(st_light),
        .valve(valve), .motor(motor), .busy(busy), .done(done)
    );

    wash_sequencer #(.CLK_HZ(4), .FILL_S(2), .WASH_S(100), .RINSE_S(2), .SPIN_S(2)) u_dut5 (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause), .mode(mode),
        .phase(phase5), .n1(n1_5), .n2(n2_5), .n3(n3_5), .n0(n0_5), .st_light(st_light5),
        .valve(valve5), .motor(motor5), .busy(busy5), .done(done5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] pk(input logic [2:0] ph, input logic [11:0] d, input logic [3:0] s0,
                                       input logic [7:0] st, input logic v, input logic [1:0] m,
                                       input logic b, input logic dn);
        pk = {ph, d, s0, st, v, m, b, dn};
    endfunction

    function automatic logic [31:0] obs();
        obs = pk(phase, {n3, n2, n1}, n0, st_light, valve, motor, busy, done);
    endfunction

    function automatic logic [31:0] obs5();
        obs5 = pk(phase5, {n3_5, n2_5, n1_5}, n0_5, st_light5, valve5, motor5, busy5, done5);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [31:0] idle_v, done_v;
    logic [11:0] d_at4, d_at360, d_at364;
    logic        bad_bcd;

    initial begin
        idle_v = pk(3'd0, 12'h000, 4'd0, 8'h00, 1'b0, 2'b00, 1'b0, 1'b0);
        done_v = pk(3'd5, 12'h000, 4'd0, 8'hFF, 1'b0, 2'b00, 1'b0, 1'b1);
        rst = 1'b1; start = 1'b0; stop = 1'b0; pause = 1'b0; mode = 2'b00;
        cyc(2);
        chk("reset_state", obs(), idle_v);
        rst = 1'b0;
        cyc(1);
        chk("idle_after_reset", obs(), idle_v);

        // Mode 00 full chain
        mode = 2'b00; start = 1'b1; cyc(1); start = 1'b0;
        chk("s1_fill_entry", obs(), pk(3'd1, 12'h002, 4'd1, 8'h01, 1'b1, 2'b00, 1'b1, 1'b0));
        cyc(4);
        chk("s1_fill_dec", obs(), pk(3'd1, 12'h001, 4'd1, 8'h01, 1'b1, 2'b00, 1'b1, 1'b0));
        cyc(3);
        chk("s1_fill_last", obs(), pk(3'd1, 12'h001, 4'd1, 8'h01, 1'b1, 2'b00, 1'b1, 1'b0));
        cyc(1);
        chk("s1_wash_entry", obs(), pk(3'd2, 12'h003, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(11);
        chk("s1_wash_last", obs(), pk(3'd2, 12'h001, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(1);
        chk("s1_rinse_entry", obs(), pk(3'd3, 12'h002, 4'd3, 8'h07, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(8);
        chk("s1_spin_entry", obs(), pk(3'd4, 12'h002, 4'd4, 8'h0F, 1'b0, 2'b10, 1'b1, 1'b0));
        cyc(8);
        chk("s1_done", obs(), done_v);
        pause = 1'b1; cyc(2);
        chk("s1_done_pause_ignored", obs(), done_v);
        pause = 1'b0;

        // Mode 10 spin only, busy start ignored, rerun from DONE
        mode = 2'b10; start = 1'b1; cyc(1); start = 1'b0;
        chk("s2_spin_entry", obs(), pk(3'd4, 12'h002, 4'd4, 8'h0F, 1'b0, 2'b10, 1'b1, 1'b0));
        cyc(4);
        mode = 2'b00; start = 1'b1; cyc(1); start = 1'b0;
        chk("s2_start_ignored_busy", obs(), pk(3'd4, 12'h001, 4'd4, 8'h0F, 1'b0, 2'b10, 1'b1, 1'b0));
        cyc(3);
        chk("s2_done", obs(), done_v);
        mode = 2'b10; start = 1'b1; cyc(1); start = 1'b0;
        chk("s2_rerun", obs(), pk(3'd4, 12'h002, 4'd4, 8'h0F, 1'b0, 2'b10, 1'b1, 1'b0));
        cyc(8);
        chk("s2_rerun_done", obs(), done_v);

        // Pause mid-WASH with 2 s left
        mode = 2'b00; start = 1'b1; cyc(1); start = 1'b0;
        cyc(12);
        chk("s3_wash_2left", obs(), pk(3'd2, 12'h002, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        pause = 1'b1; cyc(1);
`ifdef WASH_SEQ_PAUSE_EN
        chk("s3_paused", obs(), pk(3'd2, 12'h002, 4'd10, 8'h83, 1'b0, 2'b00, 1'b1, 1'b0));
        cyc(9);
        chk("s3_paused_hold", obs(), pk(3'd2, 12'h002, 4'd10, 8'h83, 1'b0, 2'b00, 1'b1, 1'b0));
        pause = 1'b0; cyc(1);
        chk("s3_resumed", obs(), pk(3'd2, 12'h002, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(6);
        chk("s3_wash_last", obs(), pk(3'd2, 12'h001, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(1);
        chk("s3_rinse_late", obs(), pk(3'd3, 12'h002, 4'd3, 8'h07, 1'b0, 2'b01, 1'b1, 1'b0));
`else
        chk("s3_pause_ignored", obs(), pk(3'd2, 12'h002, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(6);
        chk("s3_wash_last", obs(), pk(3'd2, 12'h001, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(1);
        chk("s3_rinse_on_time", obs(), pk(3'd3, 12'h002, 4'd3, 8'h07, 1'b0, 2'b01, 1'b1, 1'b0));
        pause = 1'b0;
`endif

        // Stop together with start during RINSE
        cyc(2);
        stop = 1'b1; start = 1'b1; cyc(1); stop = 1'b0; start = 1'b0;
        chk("s4_stop_wins", obs(), idle_v);
        cyc(4);
        chk("s4_stays_idle", obs(), idle_v);

        // Three-digit countdown on the WASH_S=100 instance, mode 01
        mode = 2'b01; start = 1'b1; cyc(1); start = 1'b0;
        chk("s5_fill_entry", obs5(), pk(3'd1, 12'h002, 4'd1, 8'h01, 1'b1, 2'b00, 1'b1, 1'b0));
        cyc(8);
        chk("s5_wash_entry", obs5(), pk(3'd2, 12'h100, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        bad_bcd = 1'b0; d_at4 = 12'h0; d_at360 = 12'h0; d_at364 = 12'h0;
        for (int i = 1; i < 400; i++) begin
            cyc(1);
            if (n1_5 > 4'd9 || n2_5 > 4'd9 || n3_5 > 4'd9) bad_bcd = 1'b1;
            if (i == 4)   d_at4   = {n3_5, n2_5, n1_5};
            if (i == 360) d_at360 = {n3_5, n2_5, n1_5};
            if (i == 364) d_at364 = {n3_5, n2_5, n1_5};
        end
        chk("s5_borrow_100_099", {20'h0, d_at4}, 32'h099);
        chk("s5_value_010", {20'h0, d_at360}, 32'h010);
        chk("s5_borrow_010_009", {20'h0, d_at364}, 32'h009);
        chk("s5_all_digits_bcd", {31'h0, bad_bcd}, 32'h0);
        chk("s5_wash_last", obs5(), pk(3'd2, 12'h001, 4'd2, 8'h03, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(1);
        chk("s5_spin_entry", obs5(), pk(3'd4, 12'h002, 4'd4, 8'h0F, 1'b0, 2'b10, 1'b1, 1'b0));
        chk("s5_short_done", obs(), done_v);
        stop = 1'b1; cyc(1); stop = 1'b0;

        // Asynchronous reset mid-FILL, then mode 11
        mode = 2'b00; start = 1'b1; cyc(1); start = 1'b0;
        cyc(3);
        #2 rst = 1'b1;
        #1;
        chk("s6_async_reset", obs(), idle_v);
        chk("s6_async_reset_b", obs5(), idle_v);
        #1 rst = 1'b0;
        cyc(1);
        chk("s6_no_resume", obs(), idle_v);
        mode = 2'b11; start = 1'b1; cyc(1); start = 1'b0;
        chk("s6_fill_entry", obs(), pk(3'd1, 12'h002, 4'd1, 8'h01, 1'b1, 2'b00, 1'b1, 1'b0));
        cyc(8);
        chk("s6_rinse_entry", obs(), pk(3'd3, 12'h002, 4'd3, 8'h07, 1'b0, 2'b01, 1'b1, 1'b0));
        cyc(8);
        chk("s6_spin_entry", obs(), pk(3'd4, 12'h002, 4'd4, 8'h0F, 1'b0, 2'b10, 1'b1, 1'b0));
        cyc(8);
        chk("s6_done", obs(), done_v);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
